// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_hazard_ctrl                                              |
// | Brief    : Pipeline stall/bubble/squash control with halt and counters.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             idex_dREN,
    input  logic [4:0]       idex_wsel,
    input  logic             ex_redirect,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             memwb_halt,
    output logic             pc_EN,
    output logic             ifid_EN,
    output logic             ifid_flush,
    output logic             idex_EN,
    output logic             idex_flush,
    output logic             exmem_EN,
    output logic             exmem_flush,
    output logic             memwb_EN,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0]       c_ST_RUN    = 2'd0;
    localparam logic [1:0]       c_ST_DWAIT  = 2'd1;
    localparam logic [1:0]       c_ST_HALTED = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_nextState;
    logic             r_halt;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    logic w_memop;
    logic w_loadUse;
    logic w_redirectActed;

    assign w_memop   = exmem_dREN | exmem_dWEN;
    // $zero is never a real producer, so it cannot create a dependency
    assign w_loadUse = idex_dREN && (idex_wsel != 5'd0) &&
                       ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));

    always_comb begin
        w_nextState     = c_ST_RUN;
        w_redirectActed = 1'b0;
        pc_EN           = 1'b1;
        ifid_EN         = 1'b1;
        ifid_flush      = 1'b0;
        idex_EN         = 1'b1;
        idex_flush      = 1'b0;
        exmem_EN        = 1'b1;
        exmem_flush     = 1'b0;
        memwb_EN        = 1'b1;
        memwb_flush     = 1'b0;

        if ((r_state == c_ST_HALTED) || memwb_halt) begin
            w_nextState = c_ST_HALTED;
            pc_EN       = 1'b0;
            ifid_EN     = 1'b0;
            idex_EN     = 1'b0;
            exmem_EN    = 1'b0;
            memwb_EN    = 1'b0;
        end else if (!dhit && (w_memop || (r_state == c_ST_DWAIT))) begin
            // Upstream frozen; WB receives a bubble while memory is busy
            w_nextState = c_ST_DWAIT;
            pc_EN       = 1'b0;
            ifid_EN     = 1'b0;
            idex_EN     = 1'b0;
            exmem_EN    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_redirect) begin
            w_redirectActed = 1'b1;
            ifid_flush      = 1'b1;
            idex_flush      = 1'b1;
        end else if (w_loadUse) begin
            pc_EN      = 1'b0;
            ifid_EN    = 1'b0;
            idex_flush = 1'b1;
        end else if (!ihit) begin
            pc_EN      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state    <= c_ST_RUN;
            r_halt     <= 1'b0;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_nextState == c_ST_HALTED) begin
                r_halt <= 1'b1;
            end
            if (!pc_EN && (r_state != c_ST_HALTED) && (r_stallCnt != c_CNT_MAX)) begin
                r_stallCnt <= r_stallCnt + c_CNT_ONE;
            end
            if (w_redirectActed && (r_flushCnt != c_CNT_MAX)) begin
                r_flushCnt <= r_flushCnt + c_CNT_ONE;
            end
        end
    end

    assign halt      = r_halt;
    assign stall_cnt = r_stallCnt;
    assign flush_cnt = r_flushCnt;

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Drives the EN and flush inputs of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Decides stalls, bubbles and squashes from cache hit signals, load-use detection, EX-stage redirects and halt.
- Holds a small state machine (RUN / DWAIT / HALTED), a sticky halt flag, and stall/flush event counters.
- Sits beside the datapath as the sole owner of pipe control.

Parameters:
CNT_W, 32, width of the saturating stall_cnt and flush_cnt counters

Ports:
CLK  in  1  clock, all state updates on rising edge
nRST  in  1  reset, synchronous, active-low
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
ifid_rs  in  5  rs field of instr in IF/ID output
ifid_rt  in  5  rt field of instr in IF/ID output
idex_dREN  in  1  ID/EX output dREN (instr in EX is a load)
idex_wsel  in  5  ID/EX output destination register
ex_redirect  in  1  EX resolved a taken branch or jump (pcSel != PC+4)
exmem_dREN  in  1  EX/MEM output dREN
exmem_dWEN  in  1  EX/MEM output dWEN
memwb_halt  in  1  MEM/WB output halt
pc_EN  out  1  PC register load enable
ifid_EN, ifid_flush  out  1 each  IF/ID control
idex_EN, idex_flush  out  1 each  ID/EX control
exmem_EN, exmem_flush  out  1 each  EX/MEM control
memwb_EN, memwb_flush  out  1 each  MEM/WB control
halt  out  1  sticky halt, registered
stall_cnt  out  CNT_W  cycles with pc_EN=0 while not HALTED, saturating
flush_cnt  out  CNT_W  cycles with ex_redirect acted upon, saturating

Behaviour:
- Reset (nRST=0 at edge): state=RUN; halt=0; both counters=0. Reset is synchronous and overrides every other event in the same cycle, including mid-DWAIT.
- Control outputs are combinational from state and inputs. Default (RUN, no event): all EN=1, all flush=0.
- Events are evaluated in strict priority; only the highest active applies.
- 1. HALTED state or memwb_halt=1: every EN=0, every flush=0. HALTED is entered at the next edge and halt=1 from that edge. Only reset leaves HALTED.
- 2. memop = exmem_dREN|exmem_dWEN.
  - memop & !dhit: freeze. pc_EN, ifid_EN, idex_EN and exmem_EN are 0. memwb_EN=1 with memwb_flush=1 inserts a bubble into WB. Next state is DWAIT.
  - In DWAIT, the same outputs apply while dhit=0. The cycle dhit=1 arrives, outputs revert to lower-priority evaluation and next state is RUN.
  - memop & dhit in RUN: no stall, DWAIT not entered.
- 3. ex_redirect (not frozen by 1–2): pc_EN=1, ifid_flush=1, idex_flush=1, all EN=1; this holds regardless of ihit. flush_cnt increments.
- 4. Load-use: idex_dREN=1, idex_wsel!=0, and (idex_wsel==ifid_rs or idex_wsel==ifid_rt).
  - Outputs: pc_EN=0, ifid_EN=0, idex_EN=1, idex_flush=1; EX/MEM and MEM/WB advance.
  - Lasts exactly one cycle, since the load leaves ID/EX.
- 5. !ihit: pc_EN=0; ifid_EN=1 with ifid_flush=1 inserts a bubble; downstream advances.
- stall_cnt increments on every edge where pc_EN=0 and state!=HALTED. Both counters saturate at all-ones, no wrap.
- A redirect coinciding with a dmem stall is held; the branch stays in EX and is applied on the dhit cycle.
- memwb_halt coinciding with a dmem miss: halt wins, state goes to HALTED.
- Register 0 never causes a load-use stall.

Test Plan:
- Reset, then ihit=1, dhit=0, no memop for 5 cycles -> all EN=1, all flush=0, stall_cnt=0, flush_cnt=0, halt=0.
- exmem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles with pc/ifid/idex/exmem_EN=0 and memwb_flush=1, state DWAIT; dhit cycle all EN=1; stall_cnt=3.
- idex_dREN=1, idex_wsel=8, ifid_rt=8 -> one cycle pc_EN=0, ifid_EN=0, idex_flush=1. Repeat with idex_wsel=0, ifid_rs=0 -> no stall.
- ex_redirect=1 with ihit=0 -> pc_EN=1, ifid_flush=1, idex_flush=1, flush_cnt +1. Same redirect during dmem miss -> frozen; flush applied on the dhit cycle.
- memwb_halt=1 together with exmem_dWEN=1, dhit=0 -> all EN=0 that cycle; halt=1 next edge and stays 1 after memwb_halt drops. nRST=0 for one edge -> halt=0, state RUN.
- Force stall_cnt to 2^CNT_W-2 (CNT_W=4: 14), hold ihit=0 for 3 cycles -> 15, 15, 15.
